// File: rtl/counter_pkg.sv
// Shared definitions for the team's up and down counters: default widths and
// a ceil(log2) helper used to size prescaler phase registers.
package counter_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_WRAPW = 8;

    // ceil(log2(n)) with a floor of 1, so a divide-by-1 prescaler still has a
    // legal one-bit phase register.
    function automatic int clog2_min1(input int n);
        int bits;
        bits = 0;
        while ((1 << bits) < n) begin
            bits = bits + 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage : counter_pkg

// File: rtl/mod_up_counter_tick_gen.sv
// Prescaler: emits a one-cycle tick every PRESCALE enabled cycles. The phase
// only advances while en is high and is forced to zero by sync_clr. With
// PRESCALE=1 the phase register is stuck at zero and tick folds to a constant 1.
module tick_gen
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int PW = clog2_min1(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    // Next phase: clear wins, otherwise advance (and roll over) only when enabled.
    always_comb begin
        phase_d = phase_q;
        if (sync_clr) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
        end
    end

    // Phase register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign tick = (phase_q == LAST);

endmodule : tick_gen

// File: rtl/mod_up_counter.sv
// Programmable-modulo up counter: counts 0..modulo and wraps to 0, gated by
// en and a prescaler tick. Synchronous load (clamped to modulo) has priority
// over stepping. Each wrap pulses tc for one cycle and bumps a saturating tally.
module mod_up_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PRESCALE = 1,
    parameter int WRAPW    = DEF_WRAPW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] modulo,
    input  logic             clr_wraps,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic [WRAPW-1:0] wraps
);

    logic             tick;
    logic             step;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic [WRAPW-1:0] wraps_q, wraps_d;

    // A load restarts the prescaler so the first step lands PRESCALE cycles later.
    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .sync_clr (load),
        .tick     (tick)
    );

    assign step = en && tick && !load;

    // Next-state logic: load, then step, then hold; clr_wraps overrides the tally.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a signal unassigned, which would infer a latch.
        count_d = count_q;
        tc_d    = 1'b0;
        wraps_d = wraps_q;
        if (load) begin
            count_d = (load_val > modulo) ? modulo : load_val;
        end else if (step) begin
            if (count_q >= modulo) begin
                count_d = '0;
                tc_d    = 1'b1;
                if (wraps_q != '1) begin
                    wraps_d = wraps_q + WRAPW'(1);
                end
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
        if (clr_wraps) begin
            wraps_d = '0;
        end
    end

    // State registers; all outputs come straight from these flops.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values,
        // independent of statement order.
        if (!reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            wraps_q <= '0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            wraps_q <= wraps_d;
        end
    end

    assign counter = count_q;
    assign tc      = tc_q;
    assign wraps   = wraps_q;

endmodule : mod_up_counter

// File: tb/tb_mod_up_counter.sv
// Bench for mod_up_counter. dut_a (PRESCALE=1, WRAPW=2) runs a table of
// per-cycle vectors through a scoreboard queue; dut_p (PRESCALE=3) covers the
// prescaler and load/phase interaction with hand-written sequences.
module tb_mod_up_counter;

    typedef struct {
        logic       en;
        logic       load;
        logic [3:0] load_val;
        logic [3:0] modulo;
        logic       clr;
        logic [3:0] exp_cnt;
        logic       exp_tc;
        logic [1:0] exp_wraps;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut_a signals
    logic       rst_a = 1'b0;
    logic       en_a = 1'b0, load_a = 1'b0, clr_a = 1'b0;
    logic [3:0] lv_a = 4'd0, mod_a = 4'd9;
    logic [3:0] cnt_a;
    logic       tc_a;
    logic [1:0] wraps_a;

    // dut_p signals
    logic       rst_p = 1'b0;
    logic       en_p = 1'b0, load_p = 1'b0, clr_p = 1'b0;
    logic [3:0] lv_p = 4'd0, mod_p = 4'd15;
    logic [3:0] cnt_p;
    logic       tc_p;
    logic [7:0] wraps_p;

    int total = 0;
    int bad   = 0;

    vec_t vecs[$];
    vec_t sb[$];

    mod_up_counter #(.WIDTH(4), .PRESCALE(1), .WRAPW(2)) dut_a (
        .clk(clk), .reset(rst_a), .en(en_a), .load(load_a), .load_val(lv_a),
        .modulo(mod_a), .clr_wraps(clr_a), .counter(cnt_a), .tc(tc_a), .wraps(wraps_a)
    );

    mod_up_counter #(.WIDTH(4), .PRESCALE(3), .WRAPW(8)) dut_p (
        .clk(clk), .reset(rst_p), .en(en_p), .load(load_p), .load_val(lv_p),
        .modulo(mod_p), .clr_wraps(clr_p), .counter(cnt_p), .tc(tc_p), .wraps(wraps_p)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic load, input logic [3:0] lv,
                       input logic [3:0] md, input logic clr, input logic [3:0] ec,
                       input logic etc, input logic [1:0] ew);
        vec_t v;
        v.en = en; v.load = load; v.load_val = lv; v.modulo = md; v.clr = clr;
        v.exp_cnt = ec; v.exp_tc = etc; v.exp_wraps = ew;
        vecs.push_back(v);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        vec_t e;

        // Vector table for dut_a: inputs for one edge, then expected outputs.
        for (int i = 0; i < 3; i++) add(0, 0, 0, 9, 0, 0, 0, 0);           // hold, en=0
        for (int i = 1; i <= 9; i++) add(1, 0, 0, 9, 0, 4'(i), 0, 0);      // count 1..9
        add(1, 0, 0, 9, 0, 0, 1, 1);                                       // wrap after 9
        for (int i = 1; i <= 9; i++) add(1, 0, 0, 9, 0, 4'(i), 0, 1);      // back to 9
        add(1, 1, 12, 9, 0, 9, 0, 1);                                      // load beats wrap, clamp
        add(0, 1, 3, 9, 0, 3, 0, 1);                                       // plain load
        for (int i = 4; i <= 12; i++) add(1, 0, 0, 15, 0, 4'(i), 0, 1);    // count to 12
        add(1, 0, 0, 5, 0, 0, 1, 2);                                       // modulo shrink
        add(1, 0, 0, 0, 0, 0, 1, 3);                                       // modulo=0 wrap
        add(1, 0, 0, 0, 0, 0, 1, 3);                                       // saturated, tc stays
        add(1, 0, 0, 0, 1, 0, 1, 0);                                       // clear beats wrap
        add(0, 0, 0, 0, 0, 0, 0, 0);                                       // hold drops tc
        add(1, 1, 7, 0, 0, 0, 0, 0);                                       // load beats wrap
        add(0, 1, 15, 15, 0, 15, 0, 0);                                    // load max
        add(1, 0, 0, 15, 0, 0, 1, 1);                                      // natural wrap at max
        add(1, 0, 0, 15, 0, 1, 0, 1);
        add(0, 0, 0, 15, 0, 1, 0, 1);

        // Reset held for 30 ns.
        #25;
        check("reset cnt_a", cnt_a, 0);
        check("reset tc_a", tc_a, 0);
        check("reset wraps_a", wraps_a, 0);
        check("reset cnt_p", cnt_p, 0);
        #5;
        rst_a = 1'b1;
        rst_p = 1'b1;
        #1;

        // Table run through the scoreboard.
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            en_a = v.en; load_a = v.load; lv_a = v.load_val; mod_a = v.modulo; clr_a = v.clr;
            sb.push_back(v);
            cyc();
            e = sb.pop_front();
            check($sformatf("vec%0d cnt", i), cnt_a, e.exp_cnt);
            check($sformatf("vec%0d tc", i), tc_a, e.exp_tc);
            check($sformatf("vec%0d wraps", i), wraps_a, e.exp_wraps);
        end
        check("scoreboard drained", sb.size(), 0);

        // Mid-count asynchronous reset: outputs clear before the next edge.
        en_a = 1'b1; load_a = 1'b0; clr_a = 1'b0;
        cyc();                                   // counter 1 -> 2
        check("pre-reset cnt", cnt_a, 2);
        #2;
        rst_a = 1'b0;
        #1;
        check("async reset cnt", cnt_a, 0);
        check("async reset wraps", wraps_a, 0);
        @(negedge clk);
        rst_a = 1'b1;
        cyc();
        check("resume after reset", cnt_a, 1);
        en_a = 1'b0;

        // Prescaler: first step 3 cycles after release, four steps in 12 cycles.
        en_p = 1'b1;
        cyc(); cyc();
        check("presc 2 cyc", cnt_p, 0);
        cyc();
        check("presc 3 cyc", cnt_p, 1);
        for (int i = 0; i < 9; i++) cyc();
        check("presc 12 cyc", cnt_p, 4);
        check("presc tc", tc_p, 0);
        en_p = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        check("presc frozen", cnt_p, 4);
        en_p = 1'b1;
        cyc(); cyc();
        check("presc phase kept", cnt_p, 4);
        cyc();
        check("presc resume", cnt_p, 5);

        // Load clears the prescaler phase.
        cyc();                                   // phase now 1
        load_p = 1'b1; lv_p = 4'd2;
        cyc();
        check("presc load", cnt_p, 2);
        load_p = 1'b0;
        cyc(); cyc();
        check("presc load phase", cnt_p, 2);
        cyc();
        check("presc after load", cnt_p, 3);
        check("presc wraps", wraps_p, 0);
        en_p = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mod_up_counter

// File: doc/mod_up_counter.md
# mod_up_counter

Programmable-modulo up counter: the counting-up counterpart to the team's down counter, sharing its clock/reset and 4-bit count convention. Counts 0 to `modulo` and wraps to 0, gated by an enable and an optional clock prescaler. Supports synchronous parallel load. Flags each wrap with a one-cycle terminal-count pulse and keeps a saturating wrap tally for timers and sequencers downstream.

## Interface
- `WIDTH`, 4: count width in bits.
- `PRESCALE`, 1: clock-enable divide ratio, 1..256. A value of 1 means a step every enabled cycle.
- `WRAPW`, 8: width of the wrap tally.

- `clk`  input  1: rising-edge clock.
- `reset`  input  1: asynchronous, active-low reset.
- `en`  input  1: count enable. Also advances the prescaler.
- `load`  input  1: synchronous parallel load.
- `load_val`  input  WIDTH: value to load.
- `modulo`  input  WIDTH: terminal value. Counter sequence is 0..modulo.
- `clr_wraps`  input  1: synchronous clear of `wraps`.
- `counter`  output  WIDTH: current count.
- `tc`  output  1: one-cycle pulse, registered, asserted in the cycle `counter` first reads 0 after a wrap.
- `wraps`  output  WRAPW: saturating count of wraps.

## Operation
- Reset (`reset`=0, asynchronous), all registers cleared:
  - `counter`=0, `tc`=0, `wraps`=0.
  - Prescaler phase = 0.
- Priority at each rising edge: load, then step, then hold.
- Load (`load`=1):
  - `counter` ← min(`load_val`, `modulo`).
  - Prescaler phase ← 0.
  - No `tc`; `wraps` unchanged.
  - Load happens regardless of `en`.
- Step condition: `en`=1 and `tick`=1 and `load`=0.
  - `tick`=1 when prescaler phase == PRESCALE-1.
- Step behaviour:
  - If `counter` ≥ `modulo`: `counter` ← 0, `tc` ← 1, and `wraps` ← `wraps`+1 unless already all-ones.
  - Otherwise `counter` ← `counter`+1, `tc` ← 0.
- Hold: registers keep their value and `tc` ← 0.
- Prescaler:
  - Phase increments only when `en`=1.
  - Wraps from PRESCALE-1 to 0.
  - Frozen while `en`=0.
- Boundary cases:
  - `modulo`=0: every step yields `counter`=0 and `tc`=1.
  - `modulo` lowered below the current `counter`: the next step wraps to 0 with `tc`. The counter never runs past the max value.
  - `counter` = 2^WIDTH-1 with `modulo` = 2^WIDTH-1: natural wrap to 0 with `tc`.
  - `clr_wraps` and a wrap in the same cycle: `wraps` ← 0 (clear wins); `tc` still pulses.
  - `load` and a would-be wrap in the same cycle: load wins, no `tc`.
- Arithmetic:
  - All comparisons are unsigned WIDTH-bit.
  - Increments are WIDTH-bit with no carry-out.
  - The prescaler phase register is ceil(log2(PRESCALE)) bits, minimum 1.

## Timing
- Every output is registered. No combinational path from any input to any output.
- Latency:
  - Load → `counter` updated 1 cycle later.
  - Step → `counter` and `tc` updated 1 cycle later.
- Step rate:
  - With `en` held high, one step every PRESCALE cycles.
  - First step PRESCALE cycles after reset release or after a load.
- `tc` is exactly one cycle wide unless consecutive steps both wrap (`modulo`=0, PRESCALE=1). In that case `tc` stays high.
- Reset asserted mid-count:
  - Outputs go to 0 immediately, asynchronously.
  - After release, counting resumes from 0 on the first qualifying edge.

## Structure
- Shared package `counter_pkg`:
  - Default `WIDTH`/`WRAPW` constants.
  - `clog2`-style helper function for the prescaler width.
  - The down counter reuses the same package.
- One sub-module, `tick_gen`:
  - Ports: `clk`, `reset`, `en`, `sync_clr`, `tick`.
  - Generates `tick`; its phase is cleared by `sync_clr` (driven from `load`).
  - With PRESCALE=1 it reduces to `tick`=1 constant.
- Top level holds the counter, `tc` and `wraps` registers.

## Test plan
- Reset and hold: hold `reset`=0 for 30 ns (clk period 10 ns) → `counter`=0, `tc`=0, `wraps`=0. With `en`=0 after release, `counter` stays 0.
- Basic wrap: WIDTH=4, PRESCALE=1, `modulo`=9, `en`=1 →
  - `counter` sequence 0,1,…,9,0.
  - `tc`=1 only in the cycle reading 0 after 9.
  - `wraps`=1 after 10 steps.
- Prescaler: PRESCALE=3, `modulo`=15, `en`=1 for 12 cycles → `counter`=4. Drop `en` for 5 cycles → `counter` holds at 4 and prescaler phase is frozen.
- Load priority and clamp:
  - At `counter`=9 with `modulo`=9, assert `load`=1, `load_val`=12 → `counter`=9 next cycle, `tc`=0.
  - Then `load_val`=3 → `counter`=3.
- Modulo shrink: count to 12 with `modulo`=15, then set `modulo`=5 → next step gives `counter`=0, `tc`=1.
- Saturation, clear and mid-run reset:
  - WRAPW=2, `modulo`=0 → `wraps` reaches 3 and stays at 3.
  - `clr_wraps` coincident with a wrap → `wraps`=0.
  - Asserting `reset` low mid-count → `counter`=0 before the next clock edge.
